// File: rtl/sdram_port_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_scheduler_if
// Purpose  : Burst-command handshake between port scheduler and SDRAM engine.
// Revision : 1.0
// ============================================================================
interface sdram_port_scheduler_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 9
);
  logic              cmd_req;
  logic              cmd_wr;
  logic [1:0]        cmd_port;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_ack;
  logic              cmd_done;

  modport master (
    output cmd_req, cmd_wr, cmd_port, cmd_addr, cmd_len,
    input  cmd_ack, cmd_done
  );

  modport slave (
    input  cmd_req, cmd_wr, cmd_port, cmd_addr, cmd_len,
    output cmd_ack, cmd_done
  );
endinterface
`default_nettype wire

// File: rtl/sdram_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_scheduler
// Purpose  : Picks one of four FIFO ports per SDRAM burst and keeps frame pointers.
// Revision : 1.0
// ============================================================================
module sdram_port_scheduler #(
  parameter int unsigned FRAME_SIZE = 307200,
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned WR_LEN     = 256,
  parameter int unsigned RD_LEN     = 128,
  parameter int          ADDR_W     = 24,
  parameter int          USE_W      = 10,
  parameter int          LEN_W      = 9
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_init_done,
  input  wire logic [USE_W-1:0] i_wr1_use,
  input  wire logic [USE_W-1:0] i_wr2_use,
  input  wire logic [USE_W-1:0] i_rd1_use,
  input  wire logic [USE_W-1:0] i_rd2_use,
  input  wire logic [3:0]       i_load,
  sdram_port_scheduler_if.master cmd
);

  localparam logic [USE_W-1:0]  c_WR_THR   = USE_W'(WR_LEN);
  localparam logic [USE_W-1:0]  c_RD_THR   = USE_W'(FIFO_DEPTH - RD_LEN);
  localparam logic [USE_W-1:0]  c_RD_URG   = USE_W'(RD_LEN);
  localparam logic [ADDR_W-1:0] c_FRAME    = ADDR_W'(FRAME_SIZE);
  localparam logic [LEN_W-1:0]  c_WR_LEN   = LEN_W'(WR_LEN);
  localparam logic [LEN_W-1:0]  c_RD_LEN   = LEN_W'(RD_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_ISSUE = 2'd2,
    S_BUSY  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_req;
  logic              r_wr;
  logic [1:0]        r_port;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [1:0]        r_rr_next;
  logic              r_skip;
  logic [ADDR_W-1:0] r_ptr [4];

  logic [3:0]        w_elig;
  logic              w_urgent;
  logic              w_any;
  logic [1:0]        w_grant;
  logic [1:0]        w_idx;
  logic              w_take;
  logic              w_complete;
  logic              w_adv;
  logic [ADDR_W-1:0] w_ptr_sum;
  logic [ADDR_W-1:0] w_ptr_limit;
  logic [ADDR_W-1:0] w_ptr_wrap;

  // Odd ports (wr2, rd2) live in the second frame buffer.
  function automatic logic [ADDR_W-1:0] f_base(input logic [1:0] p);
    return p[0] ? c_FRAME : '0;
  endfunction

  assign w_elig[0] = (i_wr1_use >= c_WR_THR);
  assign w_elig[1] = (i_wr2_use >= c_WR_THR);
  assign w_elig[2] = (i_rd1_use <= c_RD_THR);
  assign w_elig[3] = (i_rd2_use <= c_RD_THR);
  assign w_urgent  = (i_rd2_use <  c_RD_URG);

  always_comb begin
    w_grant = r_rr_next;
    w_any   = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_rr_next + 2'(k);
      if (!w_any && w_elig[w_idx]) begin
        w_grant = w_idx;
        w_any   = 1'b1;
      end
    end
    // The VGA read FIFO running dry is visible on screen, so it pre-empts rotation.
    if (w_urgent) begin
      w_grant = 2'd3;
      w_any   = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_init_done) w_state_nxt = S_ARB;
      end
      S_ARB: begin
        if (!i_init_done) begin
          w_state_nxt = S_IDLE;
        end else if (w_any) begin
          w_state_nxt = S_ISSUE;
          w_take      = 1'b1;
        end
      end
      S_ISSUE: begin
        if (cmd.cmd_ack) begin
          if (cmd.cmd_done) begin
            w_complete  = 1'b1;
            w_state_nxt = i_init_done ? S_ARB : S_IDLE;
          end else begin
            w_state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (cmd.cmd_done) begin
          w_complete  = 1'b1;
          w_state_nxt = i_init_done ? S_ARB : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_wr      <= 1'b0;
      r_port    <= 2'd0;
      r_addr    <= '0;
      r_len     <= '0;
      r_rr_next <= 2'd0;
      r_skip    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_req     <= 1'b1;
        r_wr      <= ~w_grant[1];
        r_port    <= w_grant;
        r_addr    <= r_ptr[w_grant];
        r_len     <= w_grant[1] ? c_RD_LEN : c_WR_LEN;
        r_rr_next <= w_grant + 2'd1;
        r_skip    <= i_load[w_grant];
      end else begin
        if (r_state == S_ISSUE && cmd.cmd_ack) r_req <= 1'b0;
        // A reload of the in-flight port means its completion must not move the pointer.
        if ((r_state == S_ISSUE || r_state == S_BUSY) && i_load[r_port]) r_skip <= 1'b1;
      end
    end
  end

  assign w_adv       = w_complete && !r_skip && !i_load[r_port];
  assign w_ptr_sum   = r_ptr[r_port] + {{(ADDR_W-LEN_W){1'b0}}, r_len};
  assign w_ptr_limit = f_base(r_port) + c_FRAME;
  assign w_ptr_wrap  = (w_ptr_sum >= w_ptr_limit) ? f_base(r_port) : w_ptr_sum;

  always_ff @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (rst || i_load[p]) begin
        r_ptr[p] <= f_base(2'(p));
      end else if (w_adv && r_port == 2'(p)) begin
        r_ptr[p] <= w_ptr_wrap;
      end
    end
  end

  assign cmd.cmd_req  = r_req;
  assign cmd.cmd_wr   = r_wr;
  assign cmd.cmd_port = r_port;
  assign cmd.cmd_addr = r_addr;
  assign cmd.cmd_len  = r_len;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_port_scheduler
// Purpose  : Directed self-checking bench for the SDRAM burst port scheduler.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sdram_port_scheduler;

  localparam int ADDR_W = 24;
  localparam int LEN_W  = 9;
  localparam int USE_W  = 10;
  localparam int FRAME  = 307200;

  logic             clk = 1'b0;
  logic             rst;
  logic             init_done;
  logic [USE_W-1:0] wr1_use, wr2_use, rd1_use, rd2_use;
  logic [3:0]       load;

  int n_checks = 0;
  int n_fail   = 0;

  sdram_port_scheduler_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) cmd_if ();

  sdram_port_scheduler #(
    .FRAME_SIZE(307200), .FIFO_DEPTH(512), .WR_LEN(256), .RD_LEN(128),
    .ADDR_W(ADDR_W), .USE_W(USE_W), .LEN_W(LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_init_done(init_done),
    .i_wr1_use  (wr1_use),
    .i_wr2_use  (wr2_use),
    .i_rd1_use  (rd1_use),
    .i_rd2_use  (rd2_use),
    .i_load     (load),
    .cmd        (cmd_if)
  );

  always #5 clk = ~clk;

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    cmd_if.cmd_ack  = 1'b0;
    cmd_if.cmd_done = 1'b0;
    load = 4'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_use(input int w1, input int w2, input int r1, input int r2);
    wr1_use = USE_W'(w1);
    wr2_use = USE_W'(w2);
    rd1_use = USE_W'(r1);
    rd2_use = USE_W'(r2);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (cmd_if.cmd_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Engine model: accept the pending command at once and finish one cycle later.
  task automatic serve(output bit ok, output logic wr, output logic [1:0] port,
                       output logic [ADDR_W-1:0] addr, output logic [LEN_W-1:0] len);
    wait_req(ok);
    wr   = cmd_if.cmd_wr;
    port = cmd_if.cmd_port;
    addr = cmd_if.cmd_addr;
    len  = cmd_if.cmd_len;
    if (ok) begin
      cmd_if.cmd_ack = 1'b1;
      @(negedge clk);
      cmd_if.cmd_ack  = 1'b0;
      cmd_if.cmd_done = 1'b1;
      @(negedge clk);
      cmd_if.cmd_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    init_done = 1'b0;
    set_use(0, 0, 500, 500);
    do_reset();
    n_checks++;
    if ({cmd_if.cmd_req, cmd_if.cmd_wr, cmd_if.cmd_port, cmd_if.cmd_addr, cmd_if.cmd_len} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b wr=%b port=%0d addr=%0d len=%0d, required all 0",
               cmd_if.cmd_req, cmd_if.cmd_wr, cmd_if.cmd_port, cmd_if.cmd_addr, cmd_if.cmd_len);
    end
  endtask

  task automatic test_single_write();
    bit ok; bit seen;
    logic wr; logic [1:0] port; logic [ADDR_W-1:0] addr; logic [LEN_W-1:0] len;
    init_done = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (cmd_if.cmd_req !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL no_eligible_idle: cmd_req was 1, required 0");
    end
    wr1_use = USE_W'(256);
    @(negedge clk);
    n_checks++;
    if (cmd_if.cmd_req !== 1'b1 || cmd_if.cmd_wr !== 1'b1 || cmd_if.cmd_port !== 2'd0 ||
        cmd_if.cmd_addr !== 24'd0 || cmd_if.cmd_len !== 9'd256) begin
      n_fail++;
      $display("FAIL wr1_first: req=%b wr=%b port=%0d addr=%0d len=%0d, required 1 1 0 0 256",
               cmd_if.cmd_req, cmd_if.cmd_wr, cmd_if.cmd_port, cmd_if.cmd_addr, cmd_if.cmd_len);
    end
    serve(ok, wr, port, addr, len);
    serve(ok, wr, port, addr, len);
    n_checks++;
    if (!ok || wr !== 1'b1 || port !== 2'd0 || addr !== 24'd256 || len !== 9'd256) begin
      n_fail++;
      $display("FAIL wr1_second: ok=%b wr=%b port=%0d addr=%0d len=%0d, required 1 1 0 256 256",
               ok, wr, port, addr, len);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic wr; logic [1:0] port; logic [ADDR_W-1:0] addr; logic [LEN_W-1:0] len;
    logic [1:0]        exp_port [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [ADDR_W-1:0] exp_addr [5] = '{24'd0, 24'd307200, 24'd0, 24'd307200, 24'd256};
    do_reset();
    init_done = 1'b1;
    set_use(256, 256, 200, 200);
    for (int i = 0; i < 5; i++) begin
      serve(ok, wr, port, addr, len);
      n_checks++;
      if (!ok || port !== exp_port[i] || addr !== exp_addr[i] ||
          len !== (exp_port[i][1] ? 9'd128 : 9'd256) || wr !== ~exp_port[i][1]) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: ok=%b port=%0d addr=%0d len=%0d wr=%b, required port %0d addr %0d",
                 i, ok, port, addr, len, wr, exp_port[i], exp_addr[i]);
      end
    end
    rd2_use = USE_W'(50);
    serve(ok, wr, port, addr, len);
    n_checks++;
    if (!ok || port !== 2'd3 || addr !== 24'd307328 || len !== 9'd128 || wr !== 1'b0) begin
      n_fail++;
      $display("FAIL urgent_rd2: ok=%b port=%0d addr=%0d len=%0d wr=%b, required port 3 addr 307328 len 128 wr 0",
               ok, port, addr, len, wr);
    end
  endtask

  task automatic test_wrap();
    bit ok; int bad;
    logic wr; logic [1:0] port; logic [ADDR_W-1:0] addr; logic [LEN_W-1:0] len;
    logic [ADDR_W-1:0] exp;
    do_reset();
    init_done = 1'b1;
    set_use(0, 256, 500, 500);
    bad = 0;
    for (int k = 0; k <= 1200; k++) begin
      exp = (k < 1200) ? ADDR_W'(FRAME + 256 * k) : ADDR_W'(FRAME);
      serve(ok, wr, port, addr, len);
      n_checks++;
      if (!ok || port !== 2'd1 || addr !== exp) begin
        n_fail++;
        bad++;
        if (bad < 10) $display("FAIL wr2_wrap_%0d: ok=%b port=%0d addr=%0d, required port 1 addr %0d",
                               k, ok, port, addr, exp);
      end
    end
    do_reset();
    set_use(0, 0, 0, 500);
    bad = 0;
    for (int k = 0; k <= 2400; k++) begin
      exp = (k < 2400) ? ADDR_W'(128 * k) : '0;
      serve(ok, wr, port, addr, len);
      n_checks++;
      if (!ok || port !== 2'd2 || addr !== exp) begin
        n_fail++;
        bad++;
        if (bad < 10) $display("FAIL rd1_wrap_%0d: ok=%b port=%0d addr=%0d, required port 2 addr %0d",
                               k, ok, port, addr, exp);
      end
    end
  endtask

  task automatic test_load_delayed_ack();
    bit ok;
    logic wr; logic [1:0] port; logic [ADDR_W-1:0] addr; logic [LEN_W-1:0] len;
    do_reset();
    init_done = 1'b1;
    set_use(0, 0, 0, 500);
    repeat (8) serve(ok, wr, port, addr, len);
    wait_req(ok);
    n_checks++;
    if (!ok || cmd_if.cmd_addr !== 24'd1024 || cmd_if.cmd_port !== 2'd2) begin
      n_fail++;
      $display("FAIL rd1_ptr_1024: ok=%b port=%0d addr=%0d, required port 2 addr 1024",
               ok, cmd_if.cmd_port, cmd_if.cmd_addr);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (cmd_if.cmd_req !== 1'b1 || cmd_if.cmd_wr !== 1'b0 || cmd_if.cmd_port !== 2'd2 ||
          cmd_if.cmd_addr !== 24'd1024 || cmd_if.cmd_len !== 9'd128) begin
        n_fail++;
        $display("FAIL hold_stable_%0d: req=%b wr=%b port=%0d addr=%0d len=%0d, required 1 0 2 1024 128",
                 c, cmd_if.cmd_req, cmd_if.cmd_wr, cmd_if.cmd_port, cmd_if.cmd_addr, cmd_if.cmd_len);
      end
    end
    cmd_if.cmd_ack = 1'b1;
    @(negedge clk);
    cmd_if.cmd_ack = 1'b0;
    load = 4'b0100;
    @(negedge clk);
    load = 4'b0000;
    cmd_if.cmd_done = 1'b1;
    @(negedge clk);
    cmd_if.cmd_done = 1'b0;
    serve(ok, wr, port, addr, len);
    n_checks++;
    if (!ok || port !== 2'd2 || addr !== 24'd0) begin
      n_fail++;
      $display("FAIL load_in_busy: ok=%b port=%0d addr=%0d, required port 2 addr 0", ok, port, addr);
    end
    serve(ok, wr, port, addr, len);
    n_checks++;
    if (!ok || addr !== 24'd128) begin
      n_fail++;
      $display("FAIL after_load_advance: ok=%b addr=%0d, required 128", ok, addr);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    init_done = 1'b1;
    set_use(256, 0, 500, 500);
    wait_req(ok);
    cmd_if.cmd_ack  = 1'b1;
    cmd_if.cmd_done = 1'b1;
    @(negedge clk);
    cmd_if.cmd_ack  = 1'b0;
    cmd_if.cmd_done = 1'b0;
    n_checks++;
    if (cmd_if.cmd_req !== 1'b0) begin
      n_fail++;
      $display("FAIL ackdone_req_drop: cmd_req=%b, required 0", cmd_if.cmd_req);
    end
    @(negedge clk);
    n_checks++;
    if (!ok || cmd_if.cmd_req !== 1'b1 || cmd_if.cmd_addr !== 24'd256) begin
      n_fail++;
      $display("FAIL ackdone_next: ok=%b req=%b addr=%0d, required 1 1 256",
               ok, cmd_if.cmd_req, cmd_if.cmd_addr);
    end
  endtask

  task automatic test_init_drop_and_reset();
    bit ok; bit seen;
    do_reset();
    init_done = 1'b1;
    set_use(256, 0, 500, 500);
    wait_req(ok);
    cmd_if.cmd_ack = 1'b1;
    @(negedge clk);
    cmd_if.cmd_ack = 1'b0;
    init_done = 1'b0;
    @(negedge clk);
    cmd_if.cmd_done = 1'b1;
    @(negedge clk);
    cmd_if.cmd_done = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      if (cmd_if.cmd_req !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (!ok || seen) begin
      n_fail++;
      $display("FAIL init_drop_idle: ok=%b req_seen=%b, required 1 0", ok, seen);
    end
    init_done = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_if.cmd_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_to_arb_latency: cmd_req=%b, required 0", cmd_if.cmd_req);
    end
    @(negedge clk);
    n_checks++;
    if (cmd_if.cmd_req !== 1'b1 || cmd_if.cmd_addr !== 24'd256) begin
      n_fail++;
      $display("FAIL reissue_after_idle: req=%b addr=%0d, required 1 256", cmd_if.cmd_req, cmd_if.cmd_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({cmd_if.cmd_req, cmd_if.cmd_wr, cmd_if.cmd_port, cmd_if.cmd_addr, cmd_if.cmd_len} !== '0) begin
      n_fail++;
      $display("FAIL reset_in_issue: req=%b wr=%b port=%0d addr=%0d len=%0d, required all 0",
               cmd_if.cmd_req, cmd_if.cmd_wr, cmd_if.cmd_port, cmd_if.cmd_addr, cmd_if.cmd_len);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_load_delayed_ack();
    test_back_to_back();
    test_init_drop_and_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_port_scheduler.md
Name: sdram_port_scheduler

Overview:
Burst scheduler for the 4-port SDRAM frame-buffer controller. It watches the fill levels of two write FIFOs (camera grey frame, processed frame) and two read FIFOs (previous-frame read, VGA read). It picks one port per burst and issues a burst command (direction, address, length) to the SDRAM command engine. It also keeps the per-port frame address pointers, including wrap-around and reload.

Parameters:
FRAME_SIZE, 307200, words per frame buffer (640*480)
FIFO_DEPTH, 512, depth of every port FIFO in words
WR_LEN, 256, write burst length in words
RD_LEN, 128, read burst length in words
ADDR_W, 24, SDRAM word-address width
USE_W, 10, width of FIFO fill-level inputs
LEN_W, 9, width of cmd_len

Ports:
clk  in  1  single clock (SDRAM controller clock, 100 MHz)
rst  in  1  synchronous reset, active-high
init_done  in  1  SDRAM init complete; no command is issued while low
wr1_use  in  USE_W  words held in write FIFO 1 (port 0)
wr2_use  in  USE_W  words held in write FIFO 2 (port 1)
rd1_use  in  USE_W  words held in read FIFO 1 (port 2)
rd2_use  in  USE_W  words held in read FIFO 2, the VGA port (port 3)
load  in  4  per-port pointer reload to base, bit i = port i, level-sampled
cmd_req  out  1  burst command valid
cmd_wr  out  1  1 = write burst (FIFO to SDRAM), 0 = read burst
cmd_port  out  2  granted port index
cmd_addr  out  ADDR_W  burst start word address
cmd_len  out  LEN_W  burst length
cmd_ack  in  1  engine accepted the command (one-cycle pulse)
cmd_done  in  1  engine finished the burst (one-cycle pulse)

Behaviour:
- Port map:
  - port 0 = wr1, base 0.
  - port 1 = wr2, base FRAME_SIZE.
  - port 2 = rd1, base 0.
  - port 3 = rd2, base FRAME_SIZE.
  - Limit of every port = base + FRAME_SIZE.
- Eligibility, evaluated combinationally from the current inputs:
  - Write port: use >= WR_LEN.
  - Read port: use <= FIFO_DEPTH - RD_LEN.
- rd2 is urgent when rd2_use < RD_LEN. An urgent rd2 wins outright.
- Otherwise, round-robin over eligible ports starting at rr_next. rr_next resets to 0 and is set to (granted+1) mod 4 on each grant.
- FSM states: IDLE, ARB, ISSUE, BUSY.
  - IDLE: wait for init_done=1, then go to ARB.
  - ARB: if any port is eligible, latch the grant and go to ISSUE on the next cycle (1-cycle arbitration latency). Otherwise stay in ARB.
  - ISSUE: cmd_req=1. cmd_wr, cmd_port, cmd_addr and cmd_len are registered and held stable until cmd_ack. On cmd_ack, cmd_req drops the next cycle and the FSM goes to BUSY.
  - BUSY: wait for cmd_done. On cmd_done, advance the granted port's pointer and return to ARB. cmd_done outside BUSY is ignored.
- cmd_len = WR_LEN for ports 0/1 and RD_LEN for ports 2/3.
- Pointer advance: ptr += len. If the result >= limit, ptr = base. Exact wrap is guaranteed because FRAME_SIZE is a multiple of both lengths.
- load[i]=1: ptr[i] is set to base next cycle.
  - If port i is the granted port in ISSUE, the pending command is unchanged.
  - If port i is in flight (BUSY), the following cmd_done does not advance ptr[i]; ptr[i] stays at base.
  - load has priority over advance in the same cycle.
- init_done falling in ARB: return to IDLE.
- init_done falling in ISSUE or BUSY: the current command completes first, then the FSM goes to IDLE.
- cmd_ack and cmd_done in the same cycle while in ISSUE: treat as ack followed by done. The pointer advances and the FSM goes directly to ARB.
- Reset, synchronous: state=IDLE, cmd_req=0, cmd_wr=0, cmd_port=0, cmd_addr=0, cmd_len=0, rr_next=0, all pointers at their bases. Reset mid-burst simply abandons the burst.

Test Plan:
- Reset, then init_done=1 with all *_use such that no port is eligible (wr=0, rd=500) -> cmd_req stays 0 and the FSM stays in ARB.
- wr1_use=256, others ineligible -> cmd_req=1, cmd_wr=1, cmd_port=0, cmd_addr=0, cmd_len=256. After ack and done, the next wr1 burst has cmd_addr=256.
- All four ports eligible, rd2_use=200 (not urgent) -> grant order 0, 1, 2, 3, 0. Then drop rd2_use to 50 while rr_next=1 -> the next grant is port 3.
- 1200 wr2 bursts -> addresses run from 307200 to 614144 in steps of 256, then wrap to 307200. rd1 after 2400 bursts wraps to 0.
- Pulse load[2] while port 2 is in BUSY at ptr=1024 -> after done, the next rd1 cmd_addr=0. cmd fields stay stable across 5 cycles of delayed ack.
- Drop init_done during BUSY -> after done the FSM goes to IDLE and cmd_req=0. Apply rst during ISSUE -> all outputs are 0 the next cycle.
